// File: rtl/resync_pacer.sv
// resync_pacer: buffers a valid/ready word stream and emits single-cycle wr_pulse/wr_data
// strobes spaced at least MIN_GAP clk cycles apart. Optional macro: RESYNC_PACER_COALESCE_EN.
module resync_pacer #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned MIN_GAP    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_SIZE-1:0]          in_data,
  output logic                          wr_pulse,
  output logic [DATA_SIZE-1:0]          wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   coalesce_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]        wr_addr;
  logic                 full, emit, accept, push, ovw;

  assign full   = (count_q == DEPTH_C);
  assign emit   = (count_q != '0) && (gap_q == '0);
  assign accept = in_valid && in_ready;
  assign push   = accept && !ovw;

`ifdef RESYNC_PACER_COALESCE_EN
  logic [15:0] coal_q, coal_d;

  assign in_ready = 1'b1;
  // A simultaneous pop frees a slot, so only a full FIFO without an emit overwrites.
  assign ovw      = accept && full && !emit;
  assign coalesce_cnt = coal_q;

  always_comb begin
    coal_d = coal_q;
    if (ovw && (coal_q != '1)) begin
      coal_d = coal_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coal_q <= '0;
    end else begin
      coal_q <= coal_d;
    end
  end
`else
  assign in_ready     = !rst_n || !full;
  assign ovw          = 1'b0;
  assign coalesce_cnt = '0;
`endif

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    gap_d      = gap_q;
    wr_pulse_d = 1'b0;
    wr_data_d  = wr_data_q;
    wr_addr    = ovw ? (wr_ptr_q - AW'(1)) : wr_ptr_q;

    if (emit) begin
      wr_pulse_d = 1'b1;
      wr_data_d  = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
      gap_d      = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(emit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      wr_pulse_q <= wr_pulse_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && (push || ovw)) begin
      mem_q[wr_addr] <= in_data;
    end
  end

  assign wr_pulse   = wr_pulse_q;
  assign wr_data    = wr_data_q;
  assign fifo_count = count_q;

endmodule

// File: doc/resync_pacer.md
Name: resync_pacer

Overview:
- Upstream feeder for the toggle-based clock-domain-crossing stage; lives entirely in the write-clock domain.
- Accepts a valid/ready stream of data words, buffers them in a small FIFO, and emits them as single-cycle wr_pulse/wr_data strobes.
- Guarantees successive strobes are at least MIN_GAP clk cycles apart, so the CDC stage's "wr_pulse too early" condition is never hit.
- MIN_GAP is sized by the integrator from the clock ratio: at least 2 rd_clk periods plus 2 wr_clk periods of round trip, rounded up to clk cycles.

Parameters:
- DATA_SIZE, 32, width of in_data and wr_data.
- MIN_GAP, 8, minimum clk cycles from one wr_pulse to the next. Legal range is 1 or more; 1 means back-to-back pulses are allowed.
- FIFO_DEPTH, 4, number of buffered entries. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1, the single clock; it is the CDC stage's wr_clk.
- rst_n, input, 1, reset; synchronous, active-low.
- in_valid, input, 1, upstream word is valid.
- in_ready, output, 1, block accepts the word this cycle.
- in_data, input, DATA_SIZE, upstream word.
- wr_pulse, output, 1, single-cycle transfer strobe to the CDC stage.
- wr_data, output, DATA_SIZE, word qualified by wr_pulse.
- fifo_count, output, log2(FIFO_DEPTH)+1, current occupancy.
- coalesce_cnt, output, 16, saturating count of overwritten words.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO emptied: read pointer, write pointer and count all 0.
  - Gap counter set to 0.
  - wr_pulse=0, wr_data=0, coalesce_cnt=0.
  - in_ready is combinational; it reads 1 during reset.
  - Reset mid-operation discards all buffered words with no pulse emitted.
- Accept:
  - A word is accepted when in_valid and in_ready are both 1 at a clk edge.
  - The word is written at the write pointer; the write pointer wraps modulo FIFO_DEPTH.
- Emit condition, evaluated each cycle: FIFO non-empty AND gap counter == 0.
  - When true, on the next edge: wr_pulse<=1, wr_data<=FIFO head, read pointer advances (wraps), gap counter<=MIN_GAP-1.
  - Otherwise: wr_pulse<=0, wr_data holds its last value, gap counter decrements if non-zero.
- Outputs are registered. wr_data is stable from the pulse cycle until the next pulse.
- Latency: a word accepted at edge t into an empty FIFO with gap counter 0 produces wr_pulse high in the cycle after edge t+1. The accept is visible in count first, then the pop.
- Spacing: a pulse in cycle k means no pulse in cycles k+1 to k+MIN_GAP-1. MIN_GAP=1 allows a pulse every cycle.
- Simultaneous accept and emit: count is unchanged; both pointers advance.
- Full (count==FIFO_DEPTH): behaviour depends on the optional feature below.
- Empty: no pulse. The gap counter still runs down to 0 and holds there.
- in_data and in_valid are ignored when in_ready=0.

Optional Feature:
- Macro: RESYNC_PACER_COALESCE_EN
- Defined (latest-value semantics, for status words):
  - in_ready is constant 1.
  - When the FIFO is full, an accepted word overwrites the newest entry (write pointer minus 1). Pointers and count are unchanged.
  - coalesce_cnt increments and saturates at 16'hFFFF.
  - Full with an emit in the same cycle: a normal push; no overwrite.
- Not defined (lossless):
  - in_ready = (count != FIFO_DEPTH).
  - coalesce_cnt is tied to 0.

Test Plan:
- Single word, then gap check: rst_n low 2 cycles, then in_data=32'hA5A5_0001 for 1 cycle. Required: exactly one wr_pulse with wr_data=32'hA5A5_0001, 2 cycles after the accept edge; fifo_count returns to 0; wr_pulse is 0 for every cycle of reset.
- Burst with MIN_GAP=8, FIFO_DEPTH=4: 6 back-to-back words 1..6 with the macro off. Required: in_ready drops once count=4; pulses carry 1,2,3,4,5,6 in order, spaced exactly 8 cycles apart; no word lost.
- MIN_GAP=1: 4 back-to-back words. Required: wr_pulse high 4 consecutive cycles with data 1,2,3,4.
- Coalesce with the macro on, MIN_GAP=16, FIFO_DEPTH=4: words 1..7 back-to-back. Required: in_ready stays 1; emitted sequence is 1,2,3,4,7 (newest entry overwritten by 5, 6, 7 as slots allow); coalesce_cnt equals the number of overwrites.
- Reset mid-operation: 3 words queued and 1 emitted, then rst_n low 1 cycle. Required: fifo_count=0, wr_data=0, no further pulses; a new word afterwards emits after 2 cycles with no stale gap delay.
- Wrap-around: 20 words at MIN_GAP=2, FIFO_DEPTH=4, with random in_valid gaps. Required: output order matches input order across pointer wraps, and the scoreboard shows zero mismatches.
